// File: rtl/scope_pkg.sv
// rtl/scope_pkg.sv - shared sample/frame types and capture states for the spectrum path
package scope_pkg;

  localparam int SAMPLE_W  = 12;
  localparam int N_SAMPLES = 256;
  localparam int IDX_W     = $clog2(N_SAMPLES);

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef sample_t [N_SAMPLES-1:0] frame_t;

  typedef enum logic [1:0] {ARM, FILL, HOLD} cap_state_t;

endpackage

// File: rtl/trigger_detect.sv
// rtl/trigger_detect.sv - rising-edge level trigger on the accepted sample stream
module trigger_detect
  import scope_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    arm_i,
  input  logic    accept_i,
  input  logic    clear_i,
  input  logic    trig_en_i,
  input  sample_t trig_level_i,
  input  sample_t sample_i,
  output logic    trig_o
);

  sample_t prev_q, prev_d;
  logic    prev_vld_q, prev_vld_d;

  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    if (clear_i) begin
      prev_vld_d = 1'b0;
    end else if (arm_i && accept_i) begin
      prev_d     = sample_i;
      prev_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  // The first accepted sample after arming only seeds prev_q in level mode.
  assign trig_o = arm_i && accept_i &&
                  (!trig_en_i ||
                   (prev_vld_q && (prev_q < trig_level_i) && (sample_i >= trig_level_i)));

endmodule

// File: rtl/sample_frame_capture.sv
// rtl/sample_frame_capture.sv - triggered ADC frame capture; SAMPLE_FRAME_CAPTURE_TRIG_TIMEOUT_EN adds auto-trigger
module sample_frame_capture
  import scope_pkg::*;
#(
  parameter int DECIM   = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic    clk,
  input  logic    rst,
  input  sample_t adc_data,
  input  logic    adc_valid,
  input  logic    trig_en,
  input  sample_t trig_level,
  output sample_t frame [N_SAMPLES-1:0],
  output logic    frame_valid,
  input  logic    frame_ack,
  output logic    busy,
  output logic    timed_out
);

  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  cap_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DEC_W-1:0] dec_q, dec_d;
  logic             frame_valid_q, frame_valid_d;
  sample_t          frame_q [N_SAMPLES-1:0];
  logic             accept, enter_arm, trig_norm, trig, wr_en;

  assign accept    = adc_valid && (state_q != HOLD) && (dec_q == '0);
  assign enter_arm = (state_q == HOLD) && frame_ack;

  trigger_detect u_trig (
    .clk          (clk),
    .rst          (rst),
    .arm_i        (state_q == ARM),
    .accept_i     (accept),
    .clear_i      (enter_arm),
    .trig_en_i    (trig_en),
    .trig_level_i (trig_level),
    .sample_i     (adc_data),
    .trig_o       (trig_norm)
  );

`ifdef SAMPLE_FRAME_CAPTURE_TRIG_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            timed_out_q, timed_out_d;
  logic            tout_hit;

  always_comb begin
    tout_hit    = (state_q == ARM) && accept && trig_en && !trig_norm &&
                  (tcnt_q == TO_W'(TIMEOUT - 1));
    tcnt_d      = tcnt_q;
    timed_out_d = timed_out_q;
    if (enter_arm) begin
      tcnt_d = '0;
    end else if ((state_q == ARM) && accept && trig_en) begin
      tcnt_d = tcnt_q + 1'b1;
    end
    if (tout_hit) begin
      timed_out_d = 1'b1;
    end else if (trig_norm) begin
      timed_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q      <= '0;
      timed_out_q <= 1'b0;
    end else begin
      tcnt_q      <= tcnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign trig      = trig_norm || tout_hit;
  assign timed_out = timed_out_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT == 0);
  assign trig           = trig_norm;
  assign timed_out      = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    dec_d         = dec_q;
    frame_valid_d = frame_valid_q;
    wr_en         = 1'b0;
    if (adc_valid && (state_q != HOLD)) begin
      dec_d = (dec_q == DEC_W'(DECIM - 1)) ? '0 : dec_q + 1'b1;
    end
    case (state_q)
      ARM: begin
        if (trig) begin
          wr_en   = 1'b1;
          idx_d   = IDX_W'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          idx_d = idx_q + 1'b1;
          if (idx_q == '1) begin
            state_d       = HOLD;
            frame_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (frame_ack) begin
          state_d       = ARM;
          frame_valid_d = 1'b0;
          dec_d         = '0;
        end
      end
      default: state_d = ARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ARM;
      idx_q         <= '0;
      dec_q         <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      dec_q         <= dec_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  // idx_q is 0 throughout ARM, so the trigger sample lands in frame[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SAMPLES; i++) frame_q[i] <= '0;
    end else if (wr_en) begin
      frame_q[idx_q] <= adc_data;
    end
  end

  assign frame       = frame_q;
  assign frame_valid = frame_valid_q;
  assign busy        = (state_q == FILL);

endmodule

// File: tb/tb_sample_frame_capture.sv
// tb/tb_sample_frame_capture.sv - scoreboard bench for sample_frame_capture
module tb_sample_frame_capture;
  import scope_pkg::*;

  typedef struct {
    int mode;
    int start;
    int step;
    bit tmo;
  } exp_t;

  logic    clk, rst;
  sample_t adc_data, trig_level;
  logic    trig_en;
  logic    va, vb, vc, aa, ab, ac;
  sample_t fa [N_SAMPLES-1:0];
  sample_t fb [N_SAMPLES-1:0];
  sample_t fc [N_SAMPLES-1:0];
  logic    fva, fvb, fvc, bza, bzb, bzc, toa, tob, toc;
  logic    fva_q, fvb_q, fvc_q;

  exp_t qa[$], qb[$], qc[$];
  int checks = 0;
  int errors = 0;

  sample_frame_capture #(.DECIM(1), .TIMEOUT(4096)) dut_a (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(va), .trig_en(trig_en),
    .trig_level(trig_level), .frame(fa), .frame_valid(fva), .frame_ack(aa),
    .busy(bza), .timed_out(toa));

  sample_frame_capture #(.DECIM(4), .TIMEOUT(4096)) dut_b (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(vb), .trig_en(trig_en),
    .trig_level(trig_level), .frame(fb), .frame_valid(fvb), .frame_ack(ab),
    .busy(bzb), .timed_out(tob));

  sample_frame_capture #(.DECIM(1), .TIMEOUT(16)) dut_c (
    .clk(clk), .rst(rst), .adc_data(adc_data), .adc_valid(vc), .trig_en(trig_en),
    .trig_level(trig_level), .frame(fc), .frame_valid(fvc), .frame_ack(ac),
    .busy(bzc), .timed_out(toc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int stim(input int mode, input int k);
    real x;
    case (mode)
      0: return k;
      1: begin
        x = 2.0 * 3.14159265358979 * k / 64.0;
        return $rtoi(2047.5 - 2047.5 * $cos(x));
      end
      2: begin
        if (k < 2) return 3000;
        if (k == 2) return 1000;
        if (k == 3) return 2047;
        return 2044 + k;
      end
      default: return 100;
    endcase
  endfunction

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic chk_frame(input string nm, input exp_t e, input sample_t fr [N_SAMPLES-1:0],
                           input logic to, input logic bz);
    int bad;
    int want;
    bad = -1;
    want = 0;
    for (int i = 0; i < N_SAMPLES; i++) begin
      if (bad < 0 && fr[i] !== 12'(stim(e.mode, e.start + e.step * i))) begin
        bad  = i;
        want = stim(e.mode, e.start + e.step * i);
      end
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s frame[%0d]: got %0d, expected %0d", nm, bad, fr[bad], want);
    end
    check({nm, " timed_out"}, int'(to), int'(e.tmo));
    check({nm, " busy in HOLD"}, int'(bz), 0);
  endtask

  always @(negedge clk) begin
    fva_q <= fva;
    fvb_q <= fvb;
    fvc_q <= fvc;
    if (fva === 1'b1 && fva_q !== 1'b1) begin
      if (qa.size() == 0) check("A unexpected frame_valid", 1, 0);
      else chk_frame("A", qa.pop_front(), fa, toa, bza);
    end
    if (fvb === 1'b1 && fvb_q !== 1'b1) begin
      if (qb.size() == 0) check("B unexpected frame_valid", 1, 0);
      else chk_frame("B", qb.pop_front(), fb, tob, bzb);
    end
    if (fvc === 1'b1 && fvc_q !== 1'b1) begin
      if (qc.size() == 0) check("C unexpected frame_valid", 1, 0);
      else chk_frame("C", qc.pop_front(), fc, toc, bzc);
    end
  end

  task automatic drive(input int d, input bit v, input int val);
    @(negedge clk);
    adc_data = 12'(val);
    va = (d == 0) && v;
    vb = (d == 1) && v;
    vc = (d == 2) && v;
  endtask

  function automatic logic fv_of(input int d);
    return (d == 0) ? fva : (d == 1) ? fvb : fvc;
  endfunction

  task automatic wait_fv(input int d, input int budget);
    int n;
    n = 0;
    while (fv_of(d) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("dut%0d frame_valid within budget", d), int'(fv_of(d) === 1'b1), 1);
  endtask

  task automatic ack(input int d);
    @(negedge clk);
    aa = (d == 0);
    ab = (d == 1);
    ac = (d == 2);
    @(negedge clk);
    aa = 1'b0;
    ab = 1'b0;
    ac = 1'b0;
    check($sformatf("dut%0d frame_valid 1 clk after ack", d), int'(fv_of(d)), 0);
  endtask

  function automatic bit all_zero(input sample_t fr [N_SAMPLES-1:0]);
    for (int i = 0; i < N_SAMPLES; i++) if (fr[i] !== '0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    rst = 1'b1;
    adc_data = '0;
    trig_level = 12'd2048;
    trig_en = 1'b0;
    va = 0; vb = 0; vc = 0;
    aa = 0; ab = 0; ac = 0;
    repeat (3) @(negedge clk);
    check("reset frame zero", int'(all_zero(fa)), 1);
    check("reset frame_valid", int'(fva), 0);
    check("reset busy", int'(bza), 0);
    check("reset timed_out", int'(toa), 0);
    rst = 1'b0;

    // free-run ramp; samples past 255 land in HOLD and must be dropped
    qa.push_back('{0, 0, 1, 1'b0});
    for (int k = 0; k < 300; k++) begin
      drive(0, 1, k);
      if (k == 1) check("busy after first sample", int'(bza), 1);
      if (k == 255) check("frame_valid before last sample", int'(fva), 0);
      if (k == 256) check("frame_valid 1 clk after last sample", int'(fva), 1);
    end
    drive(0, 0, 0);
    check("HOLD frozen frame[0]", int'(fa[0]), 0);
    check("HOLD frozen frame[255]", int'(fa[255]), 255);
    wait_fv(0, 10);
    ack(0);

    trig_en = 1'b1;
    s = 1;
    while (!(stim(1, s - 1) < 2048 && stim(1, s) >= 2048)) s++;
    qa.push_back('{1, s, 1, 1'b0});
    for (int k = 0; k < s + 270; k++) drive(0, 1, stim(1, k));
    drive(0, 0, 0);
    wait_fv(0, 10);
    ack(0);

    qa.push_back('{2, 4, 1, 1'b0});
    for (int k = 0; k < 270; k++) begin
      drive(0, 1, stim(2, k));
      if (k == 2) check("no trigger on first sample 3000", int'(bza), 0);
    end
    drive(0, 0, 0);
    wait_fv(0, 10);
    ack(0);

    trig_en = 1'b0;
    qb.push_back('{0, 0, 4, 1'b0});
    for (int k = 0; k <= 1100; k++) begin
      if (k % 7 == 3) drive(1, 0, 4095);
      drive(1, 1, k);
    end
    drive(1, 0, 0);
    wait_fv(1, 10);
    ack(1);

    for (int k = 500; k < 600; k++) drive(0, 1, k);
    @(negedge clk);
    va = 1'b0;
    rst = 1'b1;
    #1;
    check("mid-FILL reset frame zero", int'(all_zero(fa)), 1);
    check("mid-FILL reset frame_valid", int'(fva), 0);
    check("mid-FILL reset busy", int'(bza), 0);
    @(negedge clk);
    rst = 1'b0;
    qa.push_back('{0, 700, 1, 1'b0});
    for (int k = 700; k < 956; k++) drive(0, 1, k);
    drive(0, 0, 0);
    wait_fv(0, 10);
    ack(0);

    trig_en = 1'b1;
    trig_level = 12'd2048;
`ifdef SAMPLE_FRAME_CAPTURE_TRIG_TIMEOUT_EN
    qc.push_back('{3, 0, 1, 1'b1});
    for (int k = 0; k < 14; k++) drive(2, 1, 100);
    check("no capture before 16th sample", int'(bzc), 0);
    for (int k = 14; k < 300; k++) drive(2, 1, 100);
    drive(2, 0, 0);
    wait_fv(2, 10);
    ack(2);
`else
    for (int k = 0; k < 300; k++) drive(2, 1, 100);
    drive(2, 0, 0);
    repeat (5) @(negedge clk);
    check("no timeout capture busy", int'(bzc), 0);
    check("no timeout frame_valid", int'(fvc), 0);
    check("no timeout timed_out", int'(toc), 0);
`endif

    repeat (3) @(negedge clk);
    check("queue A drained", qa.size(), 0);
    check("queue B drained", qb.size(), 0);
    check("queue C drained", qc.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
